// File: rtl/led_step_ctrl.sv
// Step-strobe generator for the 8-bit LED shifter: conditions three push-buttons
// and turns the board clock into step strobes with a selectable rate, direction and run state.
module led_step_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int BASE_DIV   = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_dir,
  input  logic       btn_pause,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed,
  output logic       running
);

  localparam int PW = $clog2(BASE_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam int B_SPEED = 0;
  localparam int B_DIR   = 1;
  localparam int B_PAUSE = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [2:0]    deb_d;
  logic [2:0]    deb_prev_q;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];

  run_state_e    state_q;
  run_state_e    state_d;

  logic          dir_q;
  logic          dir_d;
  logic [1:0]    speed_q;
  logic [1:0]    speed_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [PW-1:0] period_m1;
  logic          step_q;
  logic          step_d;

  assign btn_raw = {btn_pause, btn_dir, btn_speed};

  // Two-flop synchroniser; reset too, so a held button re-debounces from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // Run/pause FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Run/pause FSM: next state.
  always_comb begin
    state_d = state_q;
    if (press[B_PAUSE]) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  // Run/pause FSM: outputs.
  always_comb begin
    running = (state_q == ST_RUN);
  end

  always_comb begin
    dir_d   = dir_q;
    speed_d = speed_q;
    if (press[B_DIR]) begin
      dir_d = ~dir_q;
    end
    if (press[B_SPEED]) begin
      speed_d = speed_q + 2'd1;
    end
  end

  always_comb begin
    period_m1 = PW'((BASE_DIV >> speed_q) - 1);
  end

  // The prescaler follows the pre-press run state, so a pause press on the
  // wrap cycle still emits that step; a speed press beats the wrap.
  always_comb begin
    presc_d = presc_q;
    step_d  = 1'b0;
    if (press[B_SPEED]) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      if (presc_q >= period_m1) begin
        presc_d = '0;
        step_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= 1'b0;
      speed_q <= 2'd0;
      presc_q <= '0;
      step_q  <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      speed_q <= speed_d;
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with DEB_CYCLES=4, BASE_DIV=16; outputs are
// sampled on the falling edge, inputs change on the falling edge.
module tb_led_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic       step;
  logic       dir;
  logic [1:0] speed;
  logic       running;

  int tests = 0;
  int fails = 0;
  int n;
  int steps;
  int bad;
  int dir_at;
  int step_at;

  led_step_ctrl #(
    .DEB_CYCLES(4),
    .BASE_DIV  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_speed(btn[0]),
    .btn_dir  (btn[1]),
    .btn_pause(btn[2]),
    .step     (step),
    .dir      (dir),
    .speed    (speed),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  // Cycles until step is seen high; -1 if the budget runs out.
  task automatic wait_step(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (step !== 1'b1 && cyc < max);
    if (step !== 1'b1) cyc = -1;
  endtask

  task automatic press_speed(input int old_s, input int new_s, input int period);
    int c;
    btn[0] = 1'b1;
    tick(6);
    chk("speed_before_latency", speed, old_s);
    tick(1);
    chk("speed_after_latency", speed, new_s);
    wait_step(40, c);
    chk("speed_new_period", c, period);
    btn[0] = 1'b0;
    tick(12);
  endtask

  initial begin
    btn = 3'b000;
    rst = 1'b1;
    tick(3);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_speed", speed, 0);
    chk("rst_running", running, 1);
    rst = 1'b0;

    // Free-running at speed 0
    wait_step(40, n);
    chk("first_step", n, 16);
    wait_step(40, n);
    chk("second_step", n, 16);
    wait_step(40, n);
    chk("third_step", n, 16);
    chk("idle_speed", speed, 0);
    chk("idle_dir", dir, 0);

    // Speed cycles 0->1->2->3->0
    press_speed(0, 1, 8);
    press_speed(1, 2, 4);
    press_speed(2, 3, 2);
    press_speed(3, 0, 16);

    // 3-cycle glitch is rejected, 4-cycle pulse is accepted
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    bad = 0;
    repeat (12) begin
      tick(1);
      if (dir !== 1'b0 || speed !== 2'd0 || running !== 1'b1) bad++;
    end
    chk("glitch_ignored", bad, 0);
    btn[1] = 1'b1;
    tick(4);
    btn[1] = 1'b0;
    tick(2);
    chk("dir_4cyc_before", dir, 0);
    tick(1);
    chk("dir_4cyc_after", dir, 1);
    tick(12);

    // Pause lands 5 cycles into a period, then resume
    wait_step(40, n);
    tick(14);
    btn[2] = 1'b1;
    tick(6);
    chk("pause_before", running, 1);
    tick(1);
    chk("pause_after", running, 0);
    btn[2] = 1'b0;
    steps = 0;
    repeat (40) begin
      tick(1);
      if (step === 1'b1) steps++;
    end
    chk("paused_no_steps", steps, 0);
    chk("still_paused", running, 0);
    btn[2] = 1'b1;
    tick(7);
    chk("resume_running", running, 1);
    btn[2] = 1'b0;
    wait_step(40, n);
    chk("resume_step", n, 11);

    // Speed and dir together, landing on the wrap cycle
    tick(9);
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    tick(6);
    chk("combo_speed_before", speed, 0);
    chk("combo_dir_before", dir, 1);
    tick(1);
    chk("combo_speed_after", speed, 1);
    chk("combo_dir_after", dir, 0);
    chk("combo_wrap_step_suppressed", step, 0);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    wait_step(40, n);
    chk("combo_next_step", n, 8);
    tick(12);

    // Build speed=2, dir=1, paused, then reset during a dir debounce
    btn[1] = 1'b1;
    tick(7);
    chk("setup_dir", dir, 1);
    btn[1] = 1'b0;
    tick(12);
    press_speed(1, 2, 4);
    btn[2] = 1'b1;
    tick(7);
    chk("setup_paused", running, 0);
    btn[2] = 1'b0;
    tick(12);
    btn[1] = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("midrst_step", step, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_speed", speed, 0);
    chk("midrst_running", running, 1);
    rst = 1'b0;
    dir_at  = -1;
    step_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (dir_at < 0 && dir === 1'b1) dir_at = i;
      if (step_at < 0 && step === 1'b1) step_at = i;
    end
    chk("held_btn_new_press", dir_at, 7);
    chk("post_rst_first_step", step_at, 16);
    btn[1] = 1'b0;
    tick(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
